multiplicator_arbiter: RTL and testbench

Shares one sequential multiplicator between NUM_REQ requesters. Round-robin selects a requester, latches its operands and pulses the multiplicator start. It waits for the done rising edge, then returns product and overflow to the winner with a one-cycle valid. A watchdog aborts a hung operation with an error response. Sits between requester blocks and the single sequential multiplicator instance.

---
 rtl/multiplicator_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_multiplicator_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicator_arbiter.sv
// multiplicator_arbiter
// Round-robin front end that time-shares one sequential multiplicator between
// NUM_REQ requesters. A winner's operands are latched, the multiplicator is
// started, and the result (or a timeout error) is returned to the winner with
// a one-cycle valid pulse. Every output comes straight from a register.

module multiplicator_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clock,
    input  logic                       reset_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*WIDTH-1:0]   multiplicand_in,
    input  logic [NUM_REQ*WIDTH-1:0]   multiplier_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic [NUM_REQ-1:0]         valid_out,
    output logic [2*WIDTH-1:0]         product_out,
    output logic                       overflow_out,
    output logic                       error_out,
    output logic                       busy_out,
    output logic [WIDTH-1:0]           mul_multiplicand_out,
    output logic [WIDTH-1:0]           mul_multiplier_out,
    output logic                       mul_start_out,
    input  logic                       mul_done_in,
    input  logic [2*WIDTH-1:0]         mul_product_in,
    input  logic                       mul_overflow_in
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_winner;
    logic [CW-1:0]        r_cnt;
    logic                 r_done_prev;

    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_valid;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_overflow;
    logic                 r_error;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_start;

    logic [PW-1:0]        w_ptr_next;
    logic [PW-1:0]        w_winner_next;
    logic [CW-1:0]        w_cnt_next;
    logic [NUM_REQ-1:0]   w_grant_next;
    logic [NUM_REQ-1:0]   w_valid_next;
    logic [2*WIDTH-1:0]   w_product_next;
    logic                 w_overflow_next;
    logic                 w_error_next;
    logic [WIDTH-1:0]     w_mcand_next;
    logic [WIDTH-1:0]     w_mplier_next;
    logic                 w_start_next;

    logic [PW-1:0]        w_rr_winner;
    logic                 w_rr_found;
    logic                 w_done_rise;
    logic                 w_timeout;

    logic [WIDTH-1:0]     w_mcand_slice  [NUM_REQ];
    logic [WIDTH-1:0]     w_mplier_slice [NUM_REQ];

    // Unpack the flat operand buses into per-requester slices
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_mcand_slice[gi]  = multiplicand_in[gi*WIDTH +: WIDTH];
            assign w_mplier_slice[gi] = multiplier_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Only a fresh 0->1 transition of done counts; a level left high by the
    // previous operation must fall first.
    assign w_done_rise = mul_done_in & ~r_done_prev;

    // WAIT lasts TIMEOUT-1 cycles at most, so the error response lands
    // exactly TIMEOUT cycles after the START cycle.
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 2));

    // Round-robin search: first requesting index after the last winner
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_rr_found && req_in[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = PW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_rr_found) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT:  if (w_done_rise || w_timeout) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low, data holds
    always_comb begin
        w_ptr_next      = r_ptr;
        w_winner_next   = r_winner;
        w_cnt_next      = r_cnt;
        w_grant_next    = '0;
        w_valid_next    = '0;
        w_start_next    = 1'b0;
        w_product_next  = r_product;
        w_overflow_next = r_overflow;
        w_error_next    = r_error;
        w_mcand_next    = r_mcand;
        w_mplier_next   = r_mplier;
        case (r_state)
            S_IDLE: begin
                if (w_rr_found) begin
                    w_ptr_next    = w_rr_winner;
                    w_winner_next = w_rr_winner;
                    w_mcand_next  = w_mcand_slice[w_rr_winner];
                    w_mplier_next = w_mplier_slice[w_rr_winner];
                    w_grant_next  = NUM_REQ'(1) << w_rr_winner;
                    w_start_next  = 1'b1;
                end
            end
            S_START: begin
                w_cnt_next = '0;
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_product_next  = mul_product_in;
                    w_overflow_next = mul_overflow_in;
                    w_error_next    = 1'b0;
                    w_valid_next    = NUM_REQ'(1) << r_winner;
                end else if (w_timeout) begin
                    w_product_next  = '0;
                    w_overflow_next = 1'b0;
                    w_error_next    = 1'b1;
                    w_valid_next    = NUM_REQ'(1) << r_winner;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            r_ptr       <= PW'(NUM_REQ - 1);
            r_winner    <= '0;
            r_cnt       <= '0;
            r_done_prev <= 1'b0;
            r_grant     <= '0;
            r_valid     <= '0;
            r_start     <= 1'b0;
            r_product   <= '0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_winner    <= w_winner_next;
            r_cnt       <= w_cnt_next;
            r_done_prev <= mul_done_in;
            r_grant     <= w_grant_next;
            r_valid     <= w_valid_next;
            r_start     <= w_start_next;
            r_product   <= w_product_next;
            r_overflow  <= w_overflow_next;
            r_error     <= w_error_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_mcand     <= w_mcand_next;
            r_mplier    <= w_mplier_next;
        end
    end

    assign grant_out            = r_grant;
    assign valid_out            = r_valid;
    assign product_out          = r_product;
    assign overflow_out         = r_overflow;
    assign error_out            = r_error;
    assign busy_out             = r_busy;
    assign mul_multiplicand_out = r_mcand;
    assign mul_multiplier_out   = r_mplier;
    assign mul_start_out        = r_start;

endmodule

// File: tb/tb_multiplicator_arbiter.sv
// Directed bench for multiplicator_arbiter. The bench itself plays the
// multiplicator, driving done/product/overflow with hand-computed values.

module tb_multiplicator_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TO = 20;

    logic               clock;
    logic               reset_in;
    logic [N-1:0]       req_in;
    logic [N*W-1:0]     multiplicand_in;
    logic [N*W-1:0]     multiplier_in;
    logic [N-1:0]       grant_out;
    logic [N-1:0]       valid_out;
    logic [2*W-1:0]     product_out;
    logic               overflow_out;
    logic               error_out;
    logic               busy_out;
    logic [W-1:0]       mul_multiplicand_out;
    logic [W-1:0]       mul_multiplier_out;
    logic               mul_start_out;
    logic               mul_done_in;
    logic [2*W-1:0]     mul_product_in;
    logic               mul_overflow_in;

    int checks = 0;
    int errors = 0;

    multiplicator_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clock                (clock),
        .reset_in             (reset_in),
        .req_in               (req_in),
        .multiplicand_in      (multiplicand_in),
        .multiplier_in        (multiplier_in),
        .grant_out            (grant_out),
        .valid_out            (valid_out),
        .product_out          (product_out),
        .overflow_out         (overflow_out),
        .error_out            (error_out),
        .busy_out             (busy_out),
        .mul_multiplicand_out (mul_multiplicand_out),
        .mul_multiplier_out   (mul_multiplier_out),
        .mul_start_out        (mul_start_out),
        .mul_done_in          (mul_done_in),
        .mul_product_in       (mul_product_in),
        .mul_overflow_in      (mul_overflow_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Wait (bounded) for a grant, check it and the START-cycle outputs,
    // drop the granted request, then check the pulses end after one cycle.
    task automatic wait_grant(input string tag, input logic [N-1:0] exp_g,
                              input logic [W-1:0] exp_a, input logic [W-1:0] exp_b);
        int n;
        n = 0;
        while (grant_out == '0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, grant_out, exp_g);
        chk({tag, "_start"}, mul_start_out, 1);
        chk({tag, "_busy"}, busy_out, 1);
        chk({tag, "_mcand"}, mul_multiplicand_out, exp_a);
        chk({tag, "_mplier"}, mul_multiplier_out, exp_b);
        $display("grant %s grant=%b operands=%0d,%0d", tag, grant_out, mul_multiplicand_out, mul_multiplier_out);
        req_in = req_in & ~grant_out;
        tick();
        chk({tag, "_grant_off"}, grant_out, 0);
        chk({tag, "_start_off"}, mul_start_out, 0);
    endtask

    // Raise done for one cycle with the given result, check the valid
    // response, optionally re-raise requests, and check the return to IDLE.
    task automatic finish_op(input string tag, input logic [2*W-1:0] prod, input logic ovf,
                             input logic [N-1:0] exp_v, input logic [N-1:0] reraise);
        mul_product_in  = prod;
        mul_overflow_in = ovf;
        mul_done_in     = 1'b1;
        tick();
        chk({tag, "_valid"}, valid_out, exp_v);
        chk({tag, "_product"}, product_out, prod);
        chk({tag, "_ovf"}, overflow_out, ovf);
        chk({tag, "_err"}, error_out, 0);
        $display("result %s valid=%b product=%0d ovf=%0d err=%0d", tag, valid_out, product_out, overflow_out, error_out);
        mul_done_in     = 1'b0;
        mul_overflow_in = 1'b0;
        req_in          = req_in | reraise;
        tick();
        chk({tag, "_valid_off"}, valid_out, 0);
        chk({tag, "_idle"}, busy_out, 0);
        chk({tag, "_hold"}, product_out, prod);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset_in        = 1'b1;
        req_in          = '0;
        mul_done_in     = 1'b0;
        mul_product_in  = '0;
        mul_overflow_in = 1'b0;
        multiplicand_in = {8'd1, 8'd2, 8'd3, 8'd12};
        multiplier_in   = {8'd4, 8'd5, 8'd6, 8'd11};

        // Reset state
        tick();
        chk("rst_grant", grant_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_start", mul_start_out, 0);
        chk("rst_product", product_out, 0);
        reset_in = 1'b0;
        tick();
        chk("idle_busy", busy_out, 0);

        // Single request: 12 * 11 = 132
        req_in = 4'b0001;
        wait_grant("single", 4'b0001, 8'd12, 8'd11);
        tick();
        finish_op("single", 16'd132, 1'b0, 4'b0001, 4'b0000);

        // Fairness: all four requesting, pointer at 0 -> order 1,2,3,0,1
        // Products: 5*3=15, 7*6=42, 30*9=270, 200*2=400
        multiplicand_in = {8'd200, 8'd30, 8'd7, 8'd5};
        multiplier_in   = {8'd2,   8'd9,  8'd6, 8'd3};
        req_in = 4'b1111;
        wait_grant("fair1", 4'b0010, 8'd7, 8'd6);
        finish_op("fair1", 16'd42, 1'b0, 4'b0010, 4'b0010);
        wait_grant("fair2", 4'b0100, 8'd30, 8'd9);
        finish_op("fair2", 16'd270, 1'b0, 4'b0100, 4'b0100);
        wait_grant("fair3", 4'b1000, 8'd200, 8'd2);
        finish_op("fair3", 16'd400, 1'b0, 4'b1000, 4'b1000);
        wait_grant("fair0", 4'b0001, 8'd5, 8'd3);
        finish_op("fair0", 16'd15, 1'b0, 4'b0001, 4'b0001);
        wait_grant("fair1b", 4'b0010, 8'd7, 8'd6);
        finish_op("fair1b", 16'd42, 1'b0, 4'b0010, 4'b0000);
        req_in = 4'b0000;
        tick();
        tick();

        // Timeout: done stays low; valid with error exactly TO cycles after START
        req_in = 4'b0001;
        wait_grant("tmo", 4'b0001, 8'd5, 8'd3);
        n = 1;
        while (valid_out == '0 && n < TO + 5) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, TO);
        chk("tmo_valid", valid_out, 4'b0001);
        chk("tmo_err", error_out, 1);
        chk("tmo_product", product_out, 0);
        chk("tmo_ovf", overflow_out, 0);
        $display("timeout after %0d cycles valid=%b err=%0d product=%0d", n, valid_out, error_out, product_out);
        tick();
        chk("tmo_valid_off", valid_out, 0);
        chk("tmo_err_hold", error_out, 1);

        // Arbiter serves the next request after a timeout
        req_in = 4'b0010;
        wait_grant("after_tmo", 4'b0010, 8'd7, 8'd6);
        tick();
        finish_op("after_tmo", 16'd42, 1'b0, 4'b0010, 4'b0000);

        // Reset mid-WAIT: winner 1 leaves pointer=1; after reset the pointer
        // must be 3 again, so req 0110 grants requester 1 (not 2).
        req_in = 4'b0010;
        wait_grant("mid", 4'b0010, 8'd7, 8'd6);
        tick();
        #2;
        reset_in = 1'b1;
        #1;
        chk("arst_grant", grant_out, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_busy", busy_out, 0);
        chk("arst_start", mul_start_out, 0);
        chk("arst_product", product_out, 0);
        chk("arst_mcand", mul_multiplicand_out, 0);
        chk("arst_mplier", mul_multiplier_out, 0);
        $display("async reset busy=%0d product=%0d mcand=%0d", busy_out, product_out, mul_multiplicand_out);
        tick();
        reset_in = 1'b0;
        tick();
        chk("post_rst_valid", valid_out, 0);
        chk("post_rst_busy", busy_out, 0);
        req_in = 4'b0110;
        wait_grant("rst_ptr", 4'b0010, 8'd7, 8'd6);
        finish_op("rst_ptr", 16'd42, 1'b0, 4'b0010, 4'b0000);
        wait_grant("rst_next", 4'b0100, 8'd30, 8'd9);
        finish_op("rst_next", 16'd270, 1'b0, 4'b0100, 4'b0000);

        // Priority wrap: pointer=2, req 0011 -> requester 0 before 1
        req_in = 4'b0011;
        wait_grant("wrap0", 4'b0001, 8'd5, 8'd3);
        finish_op("wrap0", 16'd15, 1'b0, 4'b0001, 4'b0000);
        wait_grant("wrap1", 4'b0010, 8'd7, 8'd6);
        finish_op("wrap1", 16'd42, 1'b0, 4'b0010, 4'b0000);

        // Stale done: done already high across START is ignored
        mul_done_in    = 1'b1;
        mul_product_in = 16'd999;
        req_in = 4'b1000;
        wait_grant("stale", 4'b1000, 8'd200, 8'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_no_valid", valid_out, 0);
            chk("stale_busy", busy_out, 1);
        end
        mul_done_in = 1'b0;
        tick();
        chk("stale_low_no_valid", valid_out, 0);
        finish_op("stale", 16'd400, 1'b1, 4'b1000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
